// File: rtl/sdram_frame_arbiter_if.sv
// Command-side bundle between the frame arbiter (master) and the FIFO/sequencer side (slave).
// Carries per-port burst requests, the single command stream and per-port status pulses.
interface sdram_frame_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]  port_req;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [PW-1:0]         cmd_port;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  burst_done;
    logic [NUM_PORTS-1:0]  port_grant;
    logic [NUM_PORTS-1:0]  frame_done;

    modport master (
        input  port_req, cmd_ready, burst_done,
        output cmd_valid, cmd_write, cmd_port, cmd_addr, port_grant, frame_done
    );

    modport slave (
        output port_req, cmd_ready, burst_done,
        input  cmd_valid, cmd_write, cmd_port, cmd_addr, port_grant, frame_done
    );
endinterface

// File: rtl/sdram_frame_arbiter.sv
// Splits SDRAM into NUM_PORTS equal frame regions, keeps a wrapping burst pointer per port
// and round-robin arbitrates port burst requests into one command stream.
//
// state   | meaning
// UNCFG   | no valid regions since reset; waits for load
// CALC    | cycle 0 computes frame size, cycles 1..NUM_PORTS build one region each
// ARB     | searches requests round-robin from the port after the last winner
// ISSUE   | command presented, held until cmd_ready
// WAIT    | burst in flight; burst_done advances/wraps the winner's address
// ERR     | last load was illegal; waits for load
module sdram_frame_arbiter #(
    parameter int                   NUM_PORTS     = 4,
    parameter int                   ADDR_WIDTH    = 23,
    parameter int                   BURST_LEN     = 8,
    parameter logic [NUM_PORTS-1:0] PORT_IS_WRITE = 'b0011
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            width,
    input  logic [15:0]            height,
    input  logic                   load,
    sdram_frame_arbiter_if.master  bus,
    output logic                   configured,
    output logic                   cfg_error
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(NUM_PORTS + 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_LEN);
    localparam logic [63:0]           ADDR_SPAN = 64'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_UNCFG,
        S_CALC,
        S_ARB,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t                state_q;
    logic [15:0]           width_q;
    logic [15:0]           height_q;
    logic [31:0]           size_q;
    logic [31:0]           size_d;
    logic [ADDR_WIDTH-1:0] base_q [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] addr_q [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] max_q  [NUM_PORTS];
    logic [CW-1:0]         calc_cnt_q;
    logic [PW-1:0]         rr_q;
    logic [PW-1:0]         win_q;
    logic                  pend_q;

    logic                  cmd_valid_q;
    logic                  cmd_write_q;
    logic [PW-1:0]         cmd_port_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [NUM_PORTS-1:0]  port_grant_q;
    logic [NUM_PORTS-1:0]  frame_done_q;
    logic                  configured_q;
    logic                  cfg_error_q;

    logic                  arb_found;
    logic [PW-1:0]         arb_win;
    logic [PW-1:0]         arb_sel;
    logic [PW-1:0]         calc_idx;
    logic [ADDR_WIDTH-1:0] calc_base;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cfg_illegal;
    logic                  start_calc;

    assign size_d      = 32'(width_q) * 32'(height_q);
    assign cfg_illegal = (size_q == 32'd0)
                      || ((size_q & 32'(BURST_LEN - 1)) != 32'd0)
                      || ((64'(size_q) * 64'(NUM_PORTS)) > ADDR_SPAN);

    // Region k is built on CALC cycle k+1, chaining off the previous region's base.
    assign calc_idx  = PW'(calc_cnt_q - CW'(1));
    assign calc_base = (calc_cnt_q == CW'(1)) ? '0
                     : base_q[PW'(calc_idx - PW'(1))] + ADDR_WIDTH'(size_q);
    assign next_addr = addr_q[win_q] + BURST_INC;

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_sel   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            arb_sel = PW'((int'(rr_q) + k) % NUM_PORTS);
            if (!arb_found && bus.port_req[arb_sel]) begin
                arb_found = 1'b1;
                arb_win   = arb_sel;
            end
        end
    end

    // A load seen mid-burst is deferred until the burst completes.
    always_comb begin
        start_calc = 1'b0;
        case (state_q)
            S_UNCFG, S_ERR, S_CALC, S_ARB: start_calc = load;
            S_WAIT:                        start_calc = bus.burst_done && (pend_q || load);
            default:                       start_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_UNCFG;
            width_q      <= '0;
            height_q     <= '0;
            size_q       <= '0;
            calc_cnt_q   <= '0;
            rr_q         <= PW'(NUM_PORTS - 1);
            win_q        <= '0;
            pend_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_port_q   <= '0;
            cmd_addr_q   <= '0;
            port_grant_q <= '0;
            frame_done_q <= '0;
            configured_q <= 1'b0;
            cfg_error_q  <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                base_q[i] <= '0;
                addr_q[i] <= '0;
                max_q[i]  <= '0;
            end
        end else begin
            frame_done_q <= '0;
            case (state_q)
                S_CALC: begin
                    if (calc_cnt_q == '0) begin
                        size_q     <= size_d;
                        calc_cnt_q <= CW'(1);
                    end else if (calc_cnt_q == CW'(1) && cfg_illegal) begin
                        state_q      <= S_ERR;
                        cfg_error_q  <= 1'b1;
                        configured_q <= 1'b0;
                    end else begin
                        base_q[calc_idx] <= calc_base;
                        addr_q[calc_idx] <= calc_base;
                        max_q[calc_idx]  <= calc_base + ADDR_WIDTH'(size_q);
                        if (calc_cnt_q == CW'(NUM_PORTS)) begin
                            state_q      <= S_ARB;
                            configured_q <= 1'b1;
                            cfg_error_q  <= 1'b0;
                        end else begin
                            calc_cnt_q <= calc_cnt_q + CW'(1);
                        end
                    end
                end
                S_ARB: begin
                    if (!load && arb_found) begin
                        rr_q         <= arb_win;
                        win_q        <= arb_win;
                        cmd_valid_q  <= 1'b1;
                        cmd_port_q   <= arb_win;
                        cmd_addr_q   <= addr_q[arb_win];
                        cmd_write_q  <= PORT_IS_WRITE[arb_win];
                        port_grant_q <= NUM_PORTS'(1) << arb_win;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.burst_done) begin
                        port_grant_q <= '0;
                        state_q      <= S_ARB;
                        if (next_addr == max_q[win_q]) begin
                            addr_q[win_q]       <= base_q[win_q];
                            frame_done_q[win_q] <= 1'b1;
                        end else begin
                            addr_q[win_q] <= next_addr;
                        end
                    end
                end
                default: ;
            endcase

            if (load) begin
                width_q      <= width;
                height_q     <= height;
                configured_q <= 1'b0;
            end
            if (load && (state_q == S_ISSUE || state_q == S_WAIT) && !start_calc) begin
                pend_q <= 1'b1;
            end
            if (start_calc) begin
                state_q      <= S_CALC;
                calc_cnt_q   <= '0;
                pend_q       <= 1'b0;
                configured_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_write  = cmd_write_q;
    assign bus.cmd_port   = cmd_port_q;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.port_grant = port_grant_q;
    assign bus.frame_done = frame_done_q;
    assign configured     = configured_q;
    assign cfg_error      = cfg_error_q;
endmodule
